// File: rtl/tlb_pipe_if.sv
// Bus bundle for tlb_pipe: two search ports, write/read access, INVTLB command
// and statistics. "slave" is the TLB side, "master" the requester side.
interface tlb_pipe_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IdxW = $clog2(TLBNUM);

  logic            s0_req;
  logic [18:0]     s0_vppn;
  logic            s0_va_bit12;
  logic [9:0]      s0_asid;
  logic            s0_rvalid;
  logic            s0_found;
  logic [IdxW-1:0] s0_index;
  logic [19:0]     s0_ppn;
  logic [5:0]      s0_ps;
  logic [5:0]      s0_attr;

  logic            s1_req;
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  logic            s1_rvalid;
  logic            s1_found;
  logic [IdxW-1:0] s1_index;
  logic [19:0]     s1_ppn;
  logic [5:0]      s1_ps;
  logic [5:0]      s1_attr;

  logic            we;
  logic            w_fill;
  logic [IdxW-1:0] w_index;
  logic [88:0]     w_entry;
  logic [IdxW-1:0] r_index;
  logic [88:0]     r_entry;
  logic [IdxW-1:0] fill_idx;

  logic            inv_valid;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;
  logic            inv_busy;

  logic [31:0]     perf_hit;
  logic [31:0]     perf_miss;

  modport slave (
    input  s0_req, s0_vppn, s0_va_bit12, s0_asid,
    input  s1_req, s1_vppn, s1_va_bit12, s1_asid,
    input  we, w_fill, w_index, w_entry, r_index,
    input  inv_valid, inv_op, inv_asid, inv_vppn,
    output s0_rvalid, s0_found, s0_index, s0_ppn, s0_ps, s0_attr,
    output s1_rvalid, s1_found, s1_index, s1_ppn, s1_ps, s1_attr,
    output r_entry, fill_idx, inv_busy, perf_hit, perf_miss
  );

  modport master (
    output s0_req, s0_vppn, s0_va_bit12, s0_asid,
    output s1_req, s1_vppn, s1_va_bit12, s1_asid,
    output we, w_fill, w_index, w_entry, r_index,
    output inv_valid, inv_op, inv_asid, inv_vppn,
    input  s0_rvalid, s0_found, s0_index, s0_ppn, s0_ps, s0_attr,
    input  s1_rvalid, s1_found, s1_index, s1_ppn, s1_ps, s1_attr,
    input  r_entry, fill_idx, inv_busy, perf_hit, perf_miss
  );
endinterface

// File: rtl/tlb_pipe.sv
// Fully associative TLB with two 1-cycle search ports, round-robin fill,
// and a multi-cycle INVTLB sweep (INV_PER_CYC entries per cycle).
// Optional: define TLB_PERF_CNT_EN to enable port-1 hit/miss counters.
// Entry layout: {e,vppn[18:0],ps[5:0],asid[9:0],g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1}.
module tlb_pipe #(
  parameter int unsigned TLBNUM      = 16,
  parameter int unsigned INV_PER_CYC = 4
) (
  input logic       clk,
  input logic       resetn,
  tlb_pipe_if.slave bus
);
  localparam int unsigned IdxW    = $clog2(TLBNUM);
  localparam int unsigned LastGrp = TLBNUM / INV_PER_CYC - 1;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [5:0]      attr;
  } res_t;

  localparam res_t MissRes = '{found: 1'b0, index: '0, ppn: '0, ps: 6'd12, attr: '0};

  typedef enum logic [0:0] {StIdle, StSweep} inv_st_e;

  // Only e is reset; the other fields are don't-care while e=0.
  logic        e_q    [TLBNUM];
  logic        e_d    [TLBNUM];
  logic [18:0] vppn_q [TLBNUM];
  logic        is22_q [TLBNUM];
  logic [9:0]  asid_q [TLBNUM];
  logic        g_q    [TLBNUM];
  logic [25:0] p0_q   [TLBNUM];  // {ppn0, plv0, mat0, d0, v0}
  logic [25:0] p1_q   [TLBNUM];

  logic [IdxW-1:0] fill_q;
  logic [IdxW-1:0] w_idx;

  inv_st_e         state_q, state_d;
  logic [IdxW-1:0] grp_q, grp_d;
  logic [2:0]      inv_op_q, inv_op_d;
  logic [9:0]      inv_asid_q, inv_asid_d;
  logic [18:0]     inv_vppn_q, inv_vppn_d;

  logic [1:0]  key_req;
  logic [18:0] key_vppn  [2];
  logic        key_bit12 [2];
  logic [9:0]  key_asid  [2];
  res_t        res_d     [2];
  res_t        res_q     [2];
  logic [1:0]  rvalid_q;

  assign key_req      = {bus.s1_req, bus.s0_req};
  assign key_vppn[0]  = bus.s0_vppn;
  assign key_vppn[1]  = bus.s1_vppn;
  assign key_bit12[0] = bus.s0_va_bit12;
  assign key_bit12[1] = bus.s1_va_bit12;
  assign key_asid[0]  = bus.s0_asid;
  assign key_asid[1]  = bus.s1_asid;

  assign w_idx = bus.w_fill ? fill_q : bus.w_index;

  // Lookup: descending scan so the lowest matching index wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      res_d[p] = MissRes;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (e_q[i] && (vppn_q[i][18:10] == key_vppn[p][18:10]) &&
            (is22_q[i] || (vppn_q[i][9:0] == key_vppn[p][9:0])) &&
            (g_q[i] || (asid_q[i] == key_asid[p]))) begin
          res_d[p].found = 1'b1;
          res_d[p].index = IdxW'(i);
          res_d[p].ps    = is22_q[i] ? 6'd22 : 6'd12;
          if (is22_q[i] ? key_vppn[p][9] : key_bit12[p]) begin
            res_d[p].ppn  = p1_q[i][25:6];
            res_d[p].attr = p1_q[i][5:0];
          end else begin
            res_d[p].ppn  = p0_q[i][25:6];
            res_d[p].attr = p0_q[i][5:0];
          end
        end
      end
    end
  end

  // Search result registers: valid for one cycle per request, data held until the next.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= '0;
      res_q[0] <= MissRes;
      res_q[1] <= MissRes;
    end else begin
      rvalid_q <= key_req;
      for (int p = 0; p < 2; p++) begin
        if (key_req[p]) res_q[p] <= res_d[p];
      end
    end
  end

  // Valid-bit next state: sweep clears the current group, a write overrides it.
  always_comb begin
    logic g, a, v, kill;
    g    = 1'b0;
    a    = 1'b0;
    v    = 1'b0;
    kill = 1'b0;
    e_d  = e_q;
    for (int i = 0; i < TLBNUM; i++) begin
      g = g_q[i];
      a = (asid_q[i] == inv_asid_q);
      v = (vppn_q[i][18:10] == inv_vppn_q[18:10]) &&
          (is22_q[i] || (vppn_q[i][9:0] == inv_vppn_q[9:0]));
      case (inv_op_q)
        3'd0, 3'd1: kill = 1'b1;
        3'd2:       kill = g;
        3'd3:       kill = !g;
        3'd4:       kill = !g && a;
        3'd5:       kill = !g && a && v;
        3'd6:       kill = (g || a) && v;
        default:    kill = 1'b0;
      endcase
      if ((state_q == StSweep) && ((i / INV_PER_CYC) == 32'(grp_q)) && kill) e_d[i] = 1'b0;
    end
    if (bus.we) e_d[w_idx] = bus.w_entry[88];
  end

  // Valid bits and fill pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) e_q[i] <= 1'b0;
      fill_q <= '0;
    end else begin
      e_q <= e_d;
      if (bus.we && bus.w_fill) fill_q <= fill_q + 1'b1;
    end
  end

  // Entry payload, not reset; non-22 page sizes are stored as 12.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      vppn_q[w_idx] <= bus.w_entry[87:69];
      is22_q[w_idx] <= (bus.w_entry[68:63] == 6'd22);
      asid_q[w_idx] <= bus.w_entry[62:53];
      g_q[w_idx]    <= bus.w_entry[52];
      p0_q[w_idx]   <= bus.w_entry[51:26];
      p1_q[w_idx]   <= bus.w_entry[25:0];
    end
  end

  // INVTLB FSM next state: accept ops 0..6 only when idle.
  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vppn_d = inv_vppn_q;
    unique case (state_q)
      StIdle: begin
        if (bus.inv_valid && (bus.inv_op <= 5'd6)) begin
          state_d    = StSweep;
          grp_d      = '0;
          inv_op_d   = bus.inv_op[2:0];
          inv_asid_d = bus.inv_asid;
          inv_vppn_d = bus.inv_vppn;
        end
      end
      StSweep: begin
        if (grp_q == IdxW'(LastGrp)) state_d = StIdle;
        else                         grp_d   = grp_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // INVTLB FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      grp_q      <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      inv_op_q   <= inv_op_d;
      inv_asid_q <= inv_asid_d;
      inv_vppn_q <= inv_vppn_d;
    end
  end

  assign bus.inv_busy = (state_q == StSweep);
  assign bus.fill_idx = fill_q;
  assign bus.r_entry  = {e_q[bus.r_index], vppn_q[bus.r_index],
                         is22_q[bus.r_index] ? 6'd22 : 6'd12, asid_q[bus.r_index],
                         g_q[bus.r_index], p0_q[bus.r_index], p1_q[bus.r_index]};

  assign bus.s0_rvalid = rvalid_q[0];
  assign bus.s0_found  = res_q[0].found;
  assign bus.s0_index  = res_q[0].index;
  assign bus.s0_ppn    = res_q[0].ppn;
  assign bus.s0_ps     = res_q[0].ps;
  assign bus.s0_attr   = res_q[0].attr;
  assign bus.s1_rvalid = rvalid_q[1];
  assign bus.s1_found  = res_q[1].found;
  assign bus.s1_index  = res_q[1].index;
  assign bus.s1_ppn    = res_q[1].ppn;
  assign bus.s1_ps     = res_q[1].ps;
  assign bus.s1_attr   = res_q[1].attr;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;

  // Port-1 statistics, one count per presented result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rvalid_q[1]) begin
      if (res_q[1].found) hit_q  <= hit_q + 32'd1;
      else                miss_q <= miss_q + 32'd1;
    end
  end

  assign bus.perf_hit  = hit_q;
  assign bus.perf_miss = miss_q;
`else
  assign bus.perf_hit  = '0;
  assign bus.perf_miss = '0;
`endif
endmodule

// File: doc/tlb_pipe.md
TLB_PIPE -- requirements
Module: tlb_pipe

Interface
REQ-001 Parameter TLBNUM, default 16, entry count; SHALL be a power of two, 4..64.
REQ-002 Parameter INV_PER_CYC, default 4, entries examined per INVTLB sweep cycle; SHALL divide TLBNUM.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 s0_req, s1_req  in  1  search request, one per port.
REQ-006 sN_vppn[18:0], sN_va_bit12, sN_asid[9:0]  in  search key per port.
REQ-007 sN_rvalid  out  1  search result valid.
REQ-008 sN_found, sN_index[$clog2(TLBNUM)-1:0], sN_ppn[19:0], sN_ps[5:0], sN_attr[5:0]  out  result per port; attr={plv,mat,d,v}.
REQ-009 we, w_fill  in  1  write enable; w_fill=1 selects fill pointer instead of w_index.
REQ-010 w_index[$clog2(TLBNUM)-1:0]  in  explicit write index.
REQ-011 w_entry[88:0], r_entry[88:0]  in/out  packed entry {e,vppn[18:0],ps[5:0],asid[9:0],g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1}.
REQ-012 r_index  in  read index; r_entry combinational from r_index.
REQ-013 fill_idx  out  current round-robin fill pointer.
REQ-014 inv_valid in 1, inv_op[4:0] in, inv_asid[9:0] in, inv_vppn[18:0] in  INVTLB command.
REQ-015 inv_busy  out  1  sweep in progress.
REQ-016 perf_hit[31:0], perf_miss[31:0]  out  port-1 search statistics.

Function
REQ-017 Match: e=1, vppn[18:10] equal, (ps==22 or vppn[9:0] equal), (asid equal or g=1); multiple matches SHALL resolve to lowest index.
REQ-018 Search latency SHALL be exactly 1 cycle: sN_req at cycle T -> sN_rvalid and result at T+1, held until the next sN_req cycle; sN_rvalid low in any cycle after no request.
REQ-019 Odd/even page select: ps==22 uses vppn[9], else va_bit12; ps not 12 or 22 on write SHALL be stored as 12.
REQ-020 Miss: sN_found=0, sN_index/ppn/attr=0, sN_ps=12.
REQ-021 Write: we at T updates entry at T+1; searches issued at T see old contents.
REQ-022 fill_idx SHALL increment on each we with w_fill=1, wrapping TLBNUM-1 -> 0; unaffected by w_fill=0 writes.
REQ-023 INVTLB FSM states IDLE, SWEEP; IDLE->SWEEP on inv_valid with op 0..6, latching op/asid/vppn; op >6 SHALL be ignored.
REQ-024 SWEEP clears e of matching entries among INV_PER_CYC consecutive entries per cycle from index 0, returning to IDLE after TLBNUM/INV_PER_CYC cycles; inv_busy=1 exactly while in SWEEP.
REQ-025 Op conditions (G=g, A=asid match, V=vppn/ps match): 0,1 all; 2 G; 3 !G; 4 !G&A; 5 !G&A&V; 6 (G|A)&V.
REQ-026 inv_valid while busy SHALL be ignored.
REQ-027 we during SWEEP: write wins for that entry in that cycle; sweep continues unchanged.
REQ-028 Searches during SWEEP SHALL be served, observing partially invalidated state.

Reset
REQ-029 resetn low SHALL immediately clear all e bits, fill_idx, sN_rvalid, result outputs (ps=12), inv_busy, perf counters, and force FSM to IDLE; other entry fields undefined.
REQ-030 Reset mid-sweep SHALL abort the sweep; no partial state retained beyond e=0.

Configuration
REQ-031 Macro TLB_PERF_CNT_EN defined: perf_hit/perf_miss SHALL count port-1 found/not-found results per s1_rvalid, wrapping at 2^32.
REQ-032 Macro undefined: counter logic SHALL be absent, perf_hit/perf_miss tied 0.

Verification
REQ-033 Reset; s0_req vppn=0x12345 -> next cycle s0_rvalid=1, found=0, ps=12.
REQ-034 Write idx 3 {e=1,vppn=0x00400,ps=22,g=1,ppn1=0xABCDE}; search vppn=0x00600 -> found=1, index=3, ppn=0xABCDE, ps=22.
REQ-035 Five we with w_fill=1, TLBNUM=4 -> entries 0,1,2,3,0 written; fill_idx=1.
REQ-036 Fill 16 entries asid=5 g=0; inv_op=4 asid=5 -> inv_busy high 4 cycles, then all r_entry e=0.
REQ-037 Entries 2 and 7 identical key -> index=2; invalidate 2 -> index=7.
REQ-038 With TLB_PERF_CNT_EN: 3 s1 hits, 2 misses -> perf_hit=3, perf_miss=2; without: both 0.
